// File: rtl/quadrant_sequencer.sv
// quadrant_sequencer: round-robin resolver tracking-loop sequencer.
// Each channel gets one select -> settle -> sample -> update dwell per scan.
// Its quadrant sign lines and MSA segment select are latched from its angle
// counter at SELECT. The counter is then stepped by the analog error reply.
module quadrant_sequencer #(
  parameter int N_CH    = 3,
  parameter int ANG_W   = 16,
  parameter int NSEG    = 4,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 64,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   load_valid,
  input  logic [CH_W-1:0]        load_ch,
  input  logic [ANG_W-1:0]       load_angle,
  input  logic                   err_valid,
  input  logic                   err_up,
  input  logic                   err_dn,
  input  logic                   fault_clr,
  output logic [CH_W-1:0]        sel_ch,
  output logic                   sin_neg,
  output logic                   cos_neg,
  output logic [NSEG-1:0]        seg_sel_n,
  output logic                   sample_req,
  output logic [N_CH-1:0]        cnt_up,
  output logic [N_CH-1:0]        cnt_dn,
  output logic [N_CH*ANG_W-1:0]  angle,
  output logic [N_CH-1:0]        fault
);

  localparam int SEG_W   = $clog2(NSEG);
  localparam int TMR_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_UPDATE = 3'd4
  } state_e;

  // Quadrant/segment decode of one angle: {sin_neg, cos_neg, seg_sel_n}.
  function automatic logic [NSEG+1:0] decode_f(input logic [ANG_W-1:0] a);
    logic [1:0]       q;
    logic [SEG_W-1:0] s;
    logic [NSEG-1:0]  onehot;
    q      = a[ANG_W-1 -: 2];
    s      = a[ANG_W-3 -: SEG_W];
    onehot = NSEG'(1) << s;
    return {q[1], q[1] ^ q[0], ~onehot};
  endfunction

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [CH_W-1:0]        sel_ch_q, sel_ch_d;
  logic                   sin_neg_q, sin_neg_d;
  logic                   cos_neg_q, cos_neg_d;
  logic [NSEG-1:0]        seg_sel_n_q, seg_sel_n_d;
  logic                   sample_req_q, sample_req_d;
  logic [N_CH-1:0]        cnt_up_q, cnt_up_d;
  logic [N_CH-1:0]        cnt_dn_q, cnt_dn_d;
  logic [N_CH-1:0]        fault_q, fault_d;
  logic [N_CH*ANG_W-1:0]  angle_q, angle_d;
  logic                   step_up_q, step_up_d;
  logic                   step_dn_q, step_dn_d;

  logic [ANG_W-1:0]       cur_angle_s;
  logic                   settle_done_s;
  logic                   timeout_s;
  logic                   load_ok_s;
  logic                   load_hit_s;

  assign cur_angle_s   = angle_q[int'(sel_ch_q)*ANG_W +: ANG_W];
  assign settle_done_s = (tmr_q == TMR_W'(SETTLE - 1));
  assign timeout_s     = (state_q == S_SAMPLE) && !err_valid &&
                         (tmr_q == TMR_W'(TIMEOUT - 1));
  assign load_ok_s     = load_valid && (int'(load_ch) < N_CH);
  // A load onto the channel being stepped overrides the step and its pulse.
  assign load_hit_s    = load_ok_s && (load_ch == sel_ch_q);

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM next-state logic; a dwell always runs through UPDATE once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SELECT;
        else        state_d = S_IDLE;
      end
      S_SELECT: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_done_s) state_d = S_SAMPLE;
        else               state_d = S_SETTLE;
      end
      S_SAMPLE: begin
        if (err_valid || timeout_s) state_d = S_UPDATE;
        else                        state_d = S_SAMPLE;
      end
      S_UPDATE: begin
        if (enable) state_d = S_SELECT;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: dwell timer, select latch, step, faults, loads.
  always_comb begin
    sel_ch_d     = sel_ch_q;
    sin_neg_d    = sin_neg_q;
    cos_neg_d    = cos_neg_q;
    seg_sel_n_d  = seg_sel_n_q;
    cnt_up_d     = {N_CH{1'b0}};
    cnt_dn_d     = {N_CH{1'b0}};
    angle_d      = angle_q;
    step_up_d    = step_up_q;
    step_dn_d    = step_dn_q;
    sample_req_d = (state_d == S_SAMPLE);

    if (fault_clr) fault_d = {N_CH{1'b0}};
    else           fault_d = fault_q;

    // Timer restarts on every state entry and only runs in SETTLE/SAMPLE.
    if ((state_d == state_q) && ((state_q == S_SETTLE) || (state_q == S_SAMPLE))) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = {TMR_W{1'b0}};
    end

    case (state_q)
      S_SELECT: begin
        {sin_neg_d, cos_neg_d, seg_sel_n_d} = decode_f(cur_angle_s);
      end
      S_SAMPLE: begin
        if (err_valid) begin
          step_up_d = err_up;
          step_dn_d = err_dn;
        end else if (timeout_s) begin
          step_up_d = 1'b0;
          step_dn_d = 1'b0;
          fault_d[sel_ch_q] = 1'b1;
        end else begin
          step_up_d = step_up_q;
          step_dn_d = step_dn_q;
        end
      end
      S_UPDATE: begin
        if (sel_ch_q == CH_W'(N_CH - 1)) sel_ch_d = {CH_W{1'b0}};
        else                             sel_ch_d = sel_ch_q + CH_W'(1);
        if (step_up_q && !step_dn_q) begin
          angle_d[int'(sel_ch_q)*ANG_W +: ANG_W] = cur_angle_s + ANG_W'(1);
          cnt_up_d[sel_ch_q] = !load_hit_s;
        end else if (step_dn_q && !step_up_q) begin
          angle_d[int'(sel_ch_q)*ANG_W +: ANG_W] = cur_angle_s - ANG_W'(1);
          cnt_dn_d[sel_ch_q] = !load_hit_s;
        end else begin
          angle_d = angle_q;
        end
      end
      default: begin
        sel_ch_d = sel_ch_q;
      end
    endcase

    // Direct load has the last word on the counter it targets.
    if (load_ok_s) begin
      angle_d[int'(load_ch)*ANG_W +: ANG_W] = load_angle;
    end else begin
      angle_d = angle_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q        <= {TMR_W{1'b0}};
      sel_ch_q     <= {CH_W{1'b0}};
      sin_neg_q    <= 1'b0;
      cos_neg_q    <= 1'b0;
      seg_sel_n_q  <= {NSEG{1'b1}};
      sample_req_q <= 1'b0;
      cnt_up_q     <= {N_CH{1'b0}};
      cnt_dn_q     <= {N_CH{1'b0}};
      fault_q      <= {N_CH{1'b0}};
      angle_q      <= {(N_CH*ANG_W){1'b0}};
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
    end else begin
      tmr_q        <= tmr_d;
      sel_ch_q     <= sel_ch_d;
      sin_neg_q    <= sin_neg_d;
      cos_neg_q    <= cos_neg_d;
      seg_sel_n_q  <= seg_sel_n_d;
      sample_req_q <= sample_req_d;
      cnt_up_q     <= cnt_up_d;
      cnt_dn_q     <= cnt_dn_d;
      fault_q      <= fault_d;
      angle_q      <= angle_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
    end
  end

  assign sel_ch     = sel_ch_q;
  assign sin_neg    = sin_neg_q;
  assign cos_neg    = cos_neg_q;
  assign seg_sel_n  = seg_sel_n_q;
  assign sample_req = sample_req_q;
  assign cnt_up     = cnt_up_q;
  assign cnt_dn     = cnt_dn_q;
  assign angle      = angle_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_quadrant_sequencer.sv
// tb_quadrant_sequencer: decode table, hand-written corner sequences and a
// randomized scan checked against a transaction-level model.
module tb_quadrant_sequencer;

  localparam int N_CH    = 3;
  localparam int ANG_W   = 16;
  localparam int NSEG    = 4;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;
  localparam int CH_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst, enable, load_valid;
  logic [CH_W-1:0]       load_ch;
  logic [ANG_W-1:0]      load_angle;
  logic                  err_valid, err_up, err_dn, fault_clr;
  logic [CH_W-1:0]       sel_ch;
  logic                  sin_neg, cos_neg, sample_req;
  logic [NSEG-1:0]       seg_sel_n;
  logic [N_CH-1:0]       cnt_up, cnt_dn, fault;
  logic [N_CH*ANG_W-1:0] angle;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel angles, scan pointer, sticky faults.
  logic [ANG_W-1:0] m_ang [N_CH];
  int               m_sel;
  logic [N_CH-1:0]  m_fault;

  typedef struct {
    logic [15:0] ang;
    logic        sin_e;
    logic        cos_e;
    logic [3:0]  seg_e;
  } dec_vec_t;

  typedef struct {
    bit          reply;
    int          delay;
    bit          up, dn, drop_en, noise, clr_mid, do_ld;
    int          ld_ch;
    logic [15:0] ld_val;
    bit          coll;
    int          coll_ch;
    logic [15:0] coll_val;
    bit          clr_to;
  } dwell_t;

  quadrant_sequencer #(
    .N_CH(N_CH), .ANG_W(ANG_W), .NSEG(NSEG), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
    .load_ch(load_ch), .load_angle(load_angle), .err_valid(err_valid),
    .err_up(err_up), .err_dn(err_dn), .fault_clr(fault_clr),
    .sel_ch(sel_ch), .sin_neg(sin_neg), .cos_neg(cos_neg),
    .seg_sel_n(seg_sel_n), .sample_req(sample_req), .cnt_up(cnt_up),
    .cnt_dn(cnt_dn), .angle(angle), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model decode from arithmetic on the fraction of a revolution.
  function automatic logic [5:0] m_decode(input int a);
    int quad, seg;
    logic [3:0] sn;
    quad = a / 16384;
    seg  = (a % 16384) / (16384 / NSEG);
    sn = 4'hF;
    sn[seg] = 1'b0;
    return {(quad >= 2) ? 1'b1 : 1'b0, (quad == 1 || quad == 2) ? 1'b1 : 1'b0, sn};
  endfunction

  function automatic logic [N_CH*ANG_W-1:0] m_vec();
    logic [N_CH*ANG_W-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c*ANG_W +: ANG_W] = m_ang[c];
    return v;
  endfunction

  function automatic dwell_t plain(input bit up, input bit dn);
    dwell_t d;
    d = '{reply: 1'b1, delay: 0, up: up, dn: dn, drop_en: 1'b0, noise: 1'b0,
          clr_mid: 1'b0, do_ld: 1'b0, ld_ch: 0, ld_val: 16'h0000, coll: 1'b0,
          coll_ch: 0, coll_val: 16'h0000, clr_to: 1'b0};
    return d;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_ch = '0; load_angle = '0;
    err_valid = 1'b0; err_up = 1'b0; err_dn = 1'b0; fault_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) m_ang[c] = 16'h0000;
    m_sel = 0;
    m_fault = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sel_ch"}, sel_ch, 0);
    chk({tag, "_sincos"}, {sin_neg, cos_neg}, 2'b00);
    chk({tag, "_seg"}, seg_sel_n, 4'hF);
    chk({tag, "_req"}, sample_req, 1'b0);
    chk({tag, "_pulses"}, {cnt_up, cnt_dn}, 6'd0);
    chk({tag, "_angle"}, angle, 48'd0);
    chk({tag, "_fault"}, fault, 3'd0);
  endtask

  task automatic do_load(input int ch, input logic [15:0] val);
    load_valid = 1'b1; load_ch = CH_W'(ch); load_angle = val;
    tick();
    load_valid = 1'b0;
    m_ang[ch] = val;
    chk("load_angle", angle[ch*ANG_W +: ANG_W], val);
  endtask

  task automatic start_scan();
    enable = 1'b1;
    tick();
  endtask

  // One channel dwell, entered with the FSM in SELECT.
  task automatic dwell(input dwell_t d);
    logic [5:0]      exp_dec;
    logic [N_CH-1:0] exp_up, exp_dn;
    int ch, step;
    ch = m_sel;
    exp_dec = m_decode(int'(m_ang[ch]));
    tick();
    chk("sel_ch", sel_ch, ch);
    chk("decode", {sin_neg, cos_neg, seg_sel_n}, exp_dec);
    if (d.drop_en) enable = 1'b0;
    for (int i = 0; i < SETTLE; i++) begin
      if (d.do_ld && i == 0) begin
        load_valid = 1'b1; load_ch = CH_W'(d.ld_ch); load_angle = d.ld_val;
        m_ang[d.ld_ch] = d.ld_val;
      end
      if (d.clr_mid && i == 1) begin
        fault_clr = 1'b1;
        m_fault = '0;
      end
      if (d.noise) begin
        err_valid = 1'b1; err_up = 1'($urandom_range(0, 1)); err_dn = 1'($urandom_range(0, 1));
      end
      tick();
      load_valid = 1'b0; fault_clr = 1'b0; err_valid = 1'b0; err_up = 1'b0; err_dn = 1'b0;
      chk("settle_req", sample_req, (i == SETTLE - 1));
    end
    if (d.reply) begin
      for (int j = 0; j < d.delay; j++) begin
        tick();
        chk("wait_req", sample_req, 1'b1);
      end
      err_valid = 1'b1; err_up = d.up; err_dn = d.dn;
      tick();
      err_valid = 1'b0; err_up = 1'b0; err_dn = 1'b0;
      step = (d.up && !d.dn) ? 1 : ((d.dn && !d.up) ? -1 : 0);
    end else begin
      for (int j = 0; j < TIMEOUT - 1; j++) begin
        tick();
        chk("wait_req", sample_req, 1'b1);
      end
      if (d.clr_to) fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      if (d.clr_to) m_fault = '0;
      m_fault[ch] = 1'b1;
      chk("timeout_fault", fault, m_fault);
      step = 0;
    end
    chk("req_drop", sample_req, 1'b0);
    chk("no_early_pulse", {cnt_up, cnt_dn}, 6'd0);
    if (d.coll) begin
      load_valid = 1'b1; load_ch = CH_W'(d.coll_ch); load_angle = d.coll_val;
    end
    tick();
    load_valid = 1'b0;
    exp_up = '0;
    exp_dn = '0;
    if (d.coll && d.coll_ch == ch) begin
      m_ang[ch] = d.coll_val;
    end else begin
      m_ang[ch] = 16'((int'(m_ang[ch]) + step + 65536) % 65536);
      if (step == 1) exp_up[ch] = 1'b1;
      if (step == -1) exp_dn[ch] = 1'b1;
      if (d.coll) m_ang[d.coll_ch] = d.coll_val;
    end
    m_sel = (m_sel + 1) % N_CH;
    chk("upd_angle", angle, m_vec());
    chk("upd_cnt_up", cnt_up, exp_up);
    chk("upd_cnt_dn", cnt_dn, exp_dn);
    chk("upd_sel_ch", sel_ch, m_sel);
    chk("upd_fault", fault, m_fault);
  endtask

  initial begin
    dec_vec_t dv [7];
    dwell_t   d;
    int       chg_t [$];
    int       chg_v [$];
    int       up_cnt [N_CH];
    int       prev;

    dv[0] = '{16'h0000, 1'b0, 1'b0, 4'b1110};
    dv[1] = '{16'h6000, 1'b0, 1'b1, 4'b1011};
    dv[2] = '{16'hF000, 1'b1, 1'b0, 4'b0111};
    dv[3] = '{16'hA000, 1'b1, 1'b1, 4'b1011};
    dv[4] = '{16'h4FFF, 1'b0, 1'b1, 4'b1110};
    dv[5] = '{16'hBFFF, 1'b1, 1'b1, 4'b0111};
    dv[6] = '{16'h3000, 1'b0, 1'b0, 4'b0111};

    // Reset state.
    reset_dut();
    check_reset("reset");

    // Decode table.
    for (int k = 0; k < 7; k++) begin
      reset_dut();
      do_load(0, dv[k].ang);
      start_scan();
      tick();
      chk("tbl_sin", sin_neg, dv[k].sin_e);
      chk("tbl_cos", cos_neg, dv[k].cos_e);
      chk("tbl_seg", seg_sel_n, dv[k].seg_e);
    end

    // Scan order and dwell length with err_up held high.
    reset_dut();
    enable = 1'b1; err_valid = 1'b1; err_up = 1'b1;
    prev = 0;
    for (int c = 0; c < N_CH; c++) up_cnt[c] = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      for (int c = 0; c < N_CH; c++) up_cnt[c] += int'(cnt_up[c]);
      if (int'(sel_ch) != prev) begin
        chg_t.push_back(cyc);
        chg_v.push_back(int'(sel_ch));
        prev = int'(sel_ch);
      end
    end
    err_valid = 1'b0; err_up = 1'b0;
    chk("scan_nchg", chg_t.size(), 3);
    for (int k = 0; k < chg_t.size() && k < 3; k++) begin
      chk("scan_time", chg_t[k], 8 + 7 * k);
      chk("scan_order", chg_v[k], (k + 1) % N_CH);
    end
    for (int c = 0; c < N_CH; c++) chk("scan_pulses", up_cnt[c], 1);
    chk("scan_angle", angle, {16'd1, 16'd1, 16'd1});

    // Wrap-around both ways; select lines stay frozen until the next SELECT.
    reset_dut();
    for (int c = 0; c < N_CH; c++) do_load(c, 16'hFFFF);
    start_scan();
    dwell(plain(1'b1, 1'b0));
    chk("wrap_frozen_sin", sin_neg, 1'b1);
    dwell(plain(1'b1, 1'b0));
    dwell(plain(1'b1, 1'b0));
    dwell(plain(1'b0, 1'b1));

    // Timeout, fault_clr colliding with a timeout, then plain fault_clr.
    reset_dut();
    start_scan();
    d = plain(1'b0, 1'b0); d.reply = 1'b0;
    dwell(d);
    d.clr_to = 1'b1; d.drop_en = 1'b1;
    dwell(d);
    chk("clr_to_fault", fault, 3'b010);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    m_fault = '0;
    chk("fault_clr", fault, 3'b000);

    // Collisions: load vs step on the same channel, and up+dn together.
    reset_dut();
    start_scan();
    dwell(plain(1'b1, 1'b0));
    d = plain(1'b1, 1'b0); d.coll = 1'b1; d.coll_ch = 1; d.coll_val = 16'h1234;
    dwell(d);
    dwell(plain(1'b1, 1'b1));
    d = plain(1'b0, 1'b0); d.delay = TIMEOUT - 1;
    dwell(d);

    // enable dropped mid-SETTLE: dwell completes, then the scan stays idle.
    reset_dut();
    start_scan();
    d = plain(1'b1, 1'b0); d.drop_en = 1'b1;
    dwell(d);
    for (int k = 0; k < SETTLE + 3; k++) begin
      tick();
      chk("idle_req", sample_req, 1'b0);
      chk("idle_sel", sel_ch, m_sel);
    end

    // Reset during SAMPLE with a reply pending.
    reset_dut();
    do_load(2, 16'hF000);
    start_scan();
    for (int k = 0; k < SETTLE + 1; k++) tick();
    chk("pre_rst_req", sample_req, 1'b1);
    rst = 1'b1; err_valid = 1'b1; err_up = 1'b1;
    tick();
    rst = 1'b0; err_valid = 1'b0; err_up = 1'b0;
    check_reset("rst_sample");
    tick();
    chk("post_rst_req", sample_req, 1'b0);
    chk("post_rst_angle", angle, 48'd0);

    // Randomized scan against the model.
    reset_dut();
    start_scan();
    for (int n = 0; n < 150; n++) begin
      d.reply    = ($urandom_range(0, 7) != 0);
      d.delay    = $urandom_range(0, TIMEOUT - 1);
      d.up       = 1'($urandom_range(0, 1));
      d.dn       = 1'($urandom_range(0, 1));
      d.drop_en  = ($urandom_range(0, 9) == 0);
      d.noise    = 1'($urandom_range(0, 1));
      d.clr_mid  = ($urandom_range(0, 7) == 0);
      d.do_ld    = ($urandom_range(0, 2) == 0);
      d.ld_ch    = $urandom_range(0, N_CH - 1);
      d.ld_val   = 16'($urandom);
      d.coll     = ($urandom_range(0, 5) == 0);
      d.coll_ch  = $urandom_range(0, N_CH - 1);
      d.coll_val = 16'($urandom);
      d.clr_to   = 1'($urandom_range(0, 1));
      dwell(d);
      if (d.drop_en) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          tick();
          chk("rnd_idle_req", sample_req, 1'b0);
        end
        start_scan();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadrant_sequencer.md
# quadrant_sequencer

Parametrised, clocked successor to the CDU quadrant/MSA switch selection logic. It holds a digital angle counter for each of N_CH resolver channels and scans the channels round-robin. For each channel it latches the quadrant sign and MSA segment-select lines from the counter and holds them for a settle interval. It then requests an error sample from the analog side and steps that channel's counter up or down on the reply, closing one tracking-loop iteration per channel per scan.

## Interface
Parameters:
- N_CH, 3: number of resolver channels scanned.
- ANG_W, 16: angle counter width; unsigned fraction of one revolution.
- NSEG, 4: number of MSA segments per quadrant; power of two, at least 2.
- SETTLE, 8: dwell cycles between selection and sample request; at least 1.
- TIMEOUT, 64: maximum cycles spent waiting for an error reply.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable.
- load_valid  in  1  direct counter write strobe.
- load_ch  in  $clog2(N_CH)  channel targeted by load.
- load_angle  in  ANG_W  value written on load.
- err_valid  in  1  error reply strobe.
- err_up  in  1  step the counter +1.
- err_dn  in  1  step the counter −1.
- fault_clr  in  1  clears all fault bits.
- sel_ch  out  $clog2(N_CH)  channel currently selected.
- sin_neg  out  1  sine path inverted; quadrant is 2 or 3.
- cos_neg  out  1  cosine path inverted; quadrant is 1 or 2.
- seg_sel_n  out  NSEG  one-hot, active-low MSA segment select.
- sample_req  out  1  request for an error sample.
- cnt_up  out  N_CH  one-cycle pulse when a channel increments.
- cnt_dn  out  N_CH  one-cycle pulse when a channel decrements.
- angle  out  N_CH*ANG_W  all counters, packed; channel 0 in the LSBs.
- fault  out  N_CH  sticky reply-timeout flags.

## Operation
- Decode of channel c's counter a: q = a[ANG_W-1:ANG_W-2]; s = the next $clog2(NSEG) bits.
  - sin_neg = q[1].
  - cos_neg = q[1]^q[0].
  - seg_sel_n = ~(1<<s).
- FSM states: IDLE, SELECT, SETTLE, SAMPLE, UPDATE.
- IDLE: if enable, go to SELECT.
- SELECT (1 cycle): register the decode of angle[sel_ch] onto the select outputs. Go to SETTLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE: sample_req=1.
  - On err_valid: capture err_up/err_dn and go to UPDATE.
  - After TIMEOUT cycles with no err_valid: set fault[sel_ch], make no counter change, go to UPDATE.
- UPDATE (1 cycle): apply the step, pulse cnt_up or cnt_dn for sel_ch, and advance sel_ch (N_CH−1 wraps to 0).
  - If enable: go to SELECT.
  - Otherwise: go to IDLE.
- Step rule:
  - err_up alone: +1.
  - err_dn alone: −1.
  - both or neither: no change and no pulse.
- Counter arithmetic is modulo 2^ANG_W: all-ones +1 gives 0; 0 −1 gives all-ones.
- Deasserting enable never aborts a dwell. The current channel completes through UPDATE before the FSM returns to IDLE.
- Select lines stay frozen from SELECT to the next SELECT. A counter change, including a quadrant or segment crossing, takes effect only at that channel's next SELECT.
- Load writes the counter at any time, in any state.
  - If a load hits the channel being stepped in UPDATE during the same cycle, the load value wins and no pulse is emitted.
- fault_clr clears all fault bits. If fault_clr coincides with a timeout, the timeout wins for that bit.
- err_valid outside SAMPLE is ignored.

## Timing
- Reset values: IDLE state, sel_ch=0, every counter 0, sin_neg=0, cos_neg=0, seg_sel_n all ones, sample_req=0, cnt_up=0, cnt_dn=0, fault=0.
- Reset asserted mid-dwell: all outputs take their reset values on the next edge; a pending reply is discarded.
- All outputs are registered.
- enable seen high in IDLE at edge t: select lines valid after edge t+1.
- sample_req rises SETTLE cycles after the select lines change.
- err_valid with sample_req high at edge u:
  - sample_req low after u.
  - Counter and pulse updated after u+1.
  - Next channel's select lines valid after u+2.
- Minimum dwell per channel: SETTLE+3 cycles.
- Load takes effect on the angle output one cycle after load_valid.

## Test plan
- Decode, with NSEG=4, ANG_W=16, loading each value and scanning:
  - 0x0000 → sin_neg=0, cos_neg=0, seg_sel_n=1110.
  - 0x6000 → sin_neg=0, cos_neg=1, seg_sel_n=1011.
  - 0xF000 → sin_neg=1, cos_neg=0, seg_sel_n=0111.
- Scan order and latency, with SETTLE=4 and immediate err_up replies: sel_ch runs 0,1,2,0 with 7 cycles per channel, and each channel counts +1 per scan with a single cnt_up pulse.
- Wrap-around: load 0xFFFF and apply err_up → counter 0x0000; sin_neg drops 1→0 only at the next SELECT of that channel. Load 0x0000 and apply err_dn → counter 0xFFFF.
- Timeout, with TIMEOUT=16 and no err_valid: fault[sel_ch]=1 after 16 SAMPLE cycles, counter unchanged, scan advances. fault_clr → fault=0.
- Collisions:
  - Load 0x1234 to channel 1 in the same cycle as its UPDATE with err_up → counter 0x1234, no pulse.
  - err_up and err_dn together → no change, no pulse.
- Control: enable dropped mid-SETTLE → channel completes UPDATE, then IDLE. rst asserted in SAMPLE → all reset values on the next cycle.
